// File: rtl/serial_mag_cmp_if.sv
// serial_mag_cmp_if: request/result bundle for the
// bit-serial magnitude comparator.
interface serial_mag_cmp_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             e0;
  logic             g0;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;

  modport master (
    output start, a, b, e0, g0,
    input  busy, done, eq, gt
  );

  modport slave (
    input  start, a, b, e0, g0,
    output busy, done, eq, gt
  );
endinterface

// File: rtl/serial_mag_cmp.sv
// serial_mag_cmp: LSB-first 2-bit-digit serial
// magnitude comparator with cascade-in seeds.
module serial_mag_cmp #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_mag_cmp_if.slave   bus
);
  localparam int DIGITS = WIDTH / 2;
  localparam int CW = $clog2(DIGITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             e_q, e_d;
  logic             g_q, g_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;

  logic [1:0] da;
  logic [1:0] db;
  logic       e_nx;
  logic       g_nx;

  assign da = a_q[1:0];
  assign db = b_q[1:0];

  // Running flags after the current digit; a later
  // (more significant) differing digit overrides.
  always_comb begin
    e_nx = e_q;
    g_nx = g_q;
    if (da != db) begin
      e_nx = 1'b0;
      g_nx = (da > db);
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    e_d     = e_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          e_d     = bus.e0;
          g_d     = bus.g0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 2;
        b_d   = b_q >> 2;
        e_d   = e_nx;
        g_d   = g_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          eq_d    = e_nx;
          gt_d    = g_nx;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
      cnt_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      e_q     <= e_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;
endmodule
